// File: rtl/amm_test_sequencer.sv
// Avalon-MM traffic sequencer: issues write bursts, read bursts or writes followed by reads
// from a CSR-programmed address, keeping in-flight read bursts within the tracker depth.
module amm_test_sequencer #(
    parameter int AMM_ADDR_W      = 31,
    parameter int AMM_BURST_W     = 11,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_test_i,
    input  logic [1:0]             test_mode_i,
    input  logic [AMM_ADDR_W-1:0]  start_addr_i,
    input  logic [31:0]            trans_count_i,
    input  logic [AMM_BURST_W-1:0] burst_len_i,
    input  logic                   waitrequest_i,
    input  logic                   readdatavalid_i,
    output logic [AMM_ADDR_W-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    output logic                   wr_beat_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [AMM_BURST_W-1:0] BURST_ZERO = {AMM_BURST_W{1'b0}};
    localparam logic [AMM_BURST_W-1:0] BURST_ONE  = AMM_BURST_W'(1);
    localparam logic [OUT_W-1:0]       OUT_ZERO   = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0]       OUT_ONE    = OUT_W'(1);
    localparam logic [OUT_W-1:0]       OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        RD_CMD   = 3'd2,
        RD_DRAIN = 3'd3,
        FINISH   = 3'd4
    } state_e;

    state_e                 state_r, state_s;
    logic [1:0]             mode_r, mode_s;
    logic [AMM_ADDR_W-1:0]  start_addr_r, start_addr_s;
    logic [AMM_ADDR_W-1:0]  addr_r, addr_s, addr_next_s;
    logic [31:0]            count_r, count_s, count_last_s;
    logic [31:0]            burst_cnt_r, burst_cnt_s;
    logic [AMM_BURST_W-1:0] len_r, len_s, len_last_s;
    logic [AMM_BURST_W-1:0] wr_beat_cnt_r, wr_beat_cnt_s;
    logic [AMM_BURST_W-1:0] rd_beat_cnt_r, rd_beat_cnt_s;
    logic [OUT_W-1:0]       outstanding_r, outstanding_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   wr_cmd_s, rd_cmd_s, cmd_s;
    logic                   wr_accept_s, rd_accept_s, rd_count_s, rd_last_s;

    // Command qualifiers only move on acceptance, so a stalled command stays put.
    assign wr_cmd_s     = (state_r == WR_BURST);
    assign rd_cmd_s     = (state_r == RD_CMD) && (outstanding_r < OUT_MAX) && (burst_cnt_r < count_r);
    assign cmd_s        = wr_cmd_s | rd_cmd_s;
    assign wr_accept_s  = wr_cmd_s & ~waitrequest_i;
    assign rd_accept_s  = rd_cmd_s & ~waitrequest_i;
    assign len_last_s   = len_r - BURST_ONE;
    assign count_last_s = count_r - 32'd1;
    assign addr_next_s  = addr_r + {{(AMM_ADDR_W-AMM_BURST_W){1'b0}}, len_r};
    assign rd_count_s   = readdatavalid_i && (state_r != IDLE) && (outstanding_r != OUT_ZERO);
    assign rd_last_s    = rd_count_s && (rd_beat_cnt_r == len_last_s);

    assign write_o      = wr_cmd_s;
    assign read_o       = rd_cmd_s;
    assign address_o    = cmd_s ? addr_r : {AMM_ADDR_W{1'b0}};
    assign burstcount_o = cmd_s ? len_r : BURST_ZERO;
    assign wr_beat_o    = wr_accept_s;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

    // Next-state, counter and status computation.
    always_comb begin
        state_s       = state_r;
        mode_s        = mode_r;
        start_addr_s  = start_addr_r;
        addr_s        = addr_r;
        count_s       = count_r;
        burst_cnt_s   = burst_cnt_r;
        len_s         = len_r;
        wr_beat_cnt_s = wr_beat_cnt_r;
        rd_beat_cnt_s = rd_beat_cnt_r;
        outstanding_s = outstanding_r;
        busy_s        = busy_r;
        done_s        = 1'b0;

        if (rd_last_s) begin
            rd_beat_cnt_s = BURST_ZERO;
        end else if (rd_count_s) begin
            rd_beat_cnt_s = rd_beat_cnt_r + BURST_ONE;
        end else begin
            rd_beat_cnt_s = rd_beat_cnt_r;
        end

        case ({rd_accept_s, rd_last_s})
            2'b10:   outstanding_s = outstanding_r + OUT_ONE;
            2'b01:   outstanding_s = outstanding_r - OUT_ONE;
            default: outstanding_s = outstanding_r;
        endcase

        case (state_r)
            IDLE: begin
                if (start_test_i) begin
                    mode_s        = test_mode_i;
                    start_addr_s  = start_addr_i;
                    addr_s        = start_addr_i;
                    count_s       = trans_count_i;
                    len_s         = (burst_len_i == BURST_ZERO) ? BURST_ONE : burst_len_i;
                    burst_cnt_s   = 32'd0;
                    wr_beat_cnt_s = BURST_ZERO;
                    rd_beat_cnt_s = BURST_ZERO;
                    outstanding_s = OUT_ZERO;
                    busy_s        = 1'b1;
                    if (trans_count_i == 32'd0) begin
                        state_s = FINISH;
                    end else if (test_mode_i == 2'd1) begin
                        state_s = RD_CMD;
                    end else begin
                        state_s = WR_BURST;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR_BURST: begin
                if (wr_accept_s) begin
                    if (wr_beat_cnt_r == len_last_s) begin
                        wr_beat_cnt_s = BURST_ZERO;
                        burst_cnt_s   = burst_cnt_r + 32'd1;
                        addr_s        = addr_next_s;
                        if (burst_cnt_r == count_last_s) begin
                            // Write-then-read replays the same address range for the read phase.
                            if (mode_r == 2'd2) begin
                                addr_s      = start_addr_r;
                                burst_cnt_s = 32'd0;
                                state_s     = RD_CMD;
                            end else begin
                                state_s = FINISH;
                            end
                        end else begin
                            state_s = WR_BURST;
                        end
                    end else begin
                        wr_beat_cnt_s = wr_beat_cnt_r + BURST_ONE;
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            RD_CMD: begin
                if (rd_accept_s) begin
                    burst_cnt_s = burst_cnt_r + 32'd1;
                    addr_s      = addr_next_s;
                    if (burst_cnt_r == count_last_s) begin
                        state_s = RD_DRAIN;
                    end else begin
                        state_s = RD_CMD;
                    end
                end else begin
                    state_s = RD_CMD;
                end
            end
            RD_DRAIN: begin
                if (outstanding_s == OUT_ZERO) begin
                    state_s = FINISH;
                end else begin
                    state_s = RD_DRAIN;
                end
            end
            FINISH: begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            mode_r        <= 2'd0;
            start_addr_r  <= {AMM_ADDR_W{1'b0}};
            addr_r        <= {AMM_ADDR_W{1'b0}};
            count_r       <= 32'd0;
            burst_cnt_r   <= 32'd0;
            len_r         <= BURST_ZERO;
            wr_beat_cnt_r <= BURST_ZERO;
            rd_beat_cnt_r <= BURST_ZERO;
            outstanding_r <= OUT_ZERO;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            mode_r        <= mode_s;
            start_addr_r  <= start_addr_s;
            addr_r        <= addr_s;
            count_r       <= count_s;
            burst_cnt_r   <= burst_cnt_s;
            len_r         <= len_s;
            wr_beat_cnt_r <= wr_beat_cnt_s;
            rd_beat_cnt_r <= rd_beat_cnt_s;
            outstanding_r <= outstanding_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

endmodule

// File: tb/tb_amm_test_sequencer.sv
// Bench for amm_test_sequencer: a command-list model with an in-order memory responder,
// checked every cycle, plus hand-computed timing and address expectations per scenario.
`timescale 1ns/1ps
module tb_amm_test_sequencer;

    localparam int AW   = 31;
    localparam int BW   = 11;
    localparam int MAXO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_test_i = 1'b0;
    logic [1:0]    test_mode_i = 2'd0;
    logic [AW-1:0] start_addr_i = '0;
    logic [31:0]   trans_count_i = 32'd0;
    logic [BW-1:0] burst_len_i = '0;
    logic          waitrequest_i = 1'b0;
    logic          readdatavalid_i = 1'b0;
    logic [AW-1:0] address_o;
    logic          read_o, write_o, wr_beat_o, busy_o, done_o;
    logic [BW-1:0] burstcount_o;

    amm_test_sequencer #(.AMM_ADDR_W(AW), .AMM_BURST_W(BW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_test_i(start_test_i), .test_mode_i(test_mode_i),
        .start_addr_i(start_addr_i), .trans_count_i(trans_count_i), .burst_len_i(burst_len_i),
        .waitrequest_i(waitrequest_i), .readdatavalid_i(readdatavalid_i), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burstcount_o(burstcount_o), .wr_beat_o(wr_beat_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] l;
    } cmd_t;

    cmd_t wr_q[$];
    cmd_t rd_q[$];
    int   ret_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   test_on = 1'b0;
    int   done_at = -1;
    int   last_ev = 0;
    int   phase = 0;
    int   out_m = 0;
    int   rbeats = 0;
    int   m_len = 1;
    int   lat = 20;
    int   last_sched = 0;
    bit   prev_stall = 1'b0;
    logic prev_rd, prev_wr;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_bc;

    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] rd_log[$];
    int   acc_cyc[$];
    int   rdv_cnt, max_out, first_ret, first_wr, last_wr, done_cyc, stall_cnt, busy_cnt, done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_model(input logic [1:0] mode, input logic [AW-1:0] addr,
                              input logic [31:0] cnt, input logic [BW-1:0] len);
        cmd_t c;
        logic [AW-1:0] a;
        logic [BW-1:0] l;
        a = addr;
        l = (len == '0) ? BW'(1) : len;
        wr_q.delete();
        rd_q.delete();
        out_m = 0; rbeats = 0; m_len = int'(l); last_sched = 0;
        for (int b = 0; b < int'(cnt); b++) begin
            c.a = a; c.l = l;
            if (mode != 2'd1) begin
                for (int k = 0; k < int'(l); k++) wr_q.push_back(c);
            end
            if (mode == 2'd1 || mode == 2'd2) rd_q.push_back(c);
            a = a + AW'(l);
        end
        phase = (cnt == 32'd0) ? 0 : ((wr_q.size() > 0) ? 1 : 2);
    endtask

    task automatic check_cycle();
        bit   exp_w, exp_r, exp_done, exp_busy, w_acc, r_acc;
        int   t;
        cmd_t c;
        if (rst_i) begin
            chk("reset_outputs", {read_o, write_o, wr_beat_o, busy_o, done_o, address_o, burstcount_o}, 64'd0);
            wr_q.delete(); rd_q.delete(); ret_q.delete();
            test_on = 1'b0; done_at = -1; phase = 0; out_m = 0; prev_stall = 1'b0;
            return;
        end
        exp_w    = (phase == 1) && (wr_q.size() > 0);
        exp_r    = (phase == 2) && (out_m < MAXO) && (rd_q.size() > 0);
        exp_done = (done_at >= 0) && (cyc == done_at);
        exp_busy = test_on && !exp_done;
        chk("write_o", write_o, exp_w);
        chk("read_o", read_o, exp_r);
        chk("done_o", done_o, exp_done);
        chk("busy_o", busy_o, exp_busy);
        w_acc = write_o && !waitrequest_i;
        r_acc = read_o && !waitrequest_i;
        chk("wr_beat_o", wr_beat_o, w_acc);
        if (prev_stall)
            chk("cmd_hold", {read_o, write_o, address_o, burstcount_o}, {prev_rd, prev_wr, prev_addr, prev_bc});
        if (write_o && wr_q.size() > 0) begin
            c = wr_q[0];
            chk("wr_addr", address_o, c.a);
            chk("wr_burstcount", burstcount_o, c.l);
            if (w_acc) begin
                void'(wr_q.pop_front());
                wr_log.push_back(address_o);
                if (wr_log.size() == 1) first_wr = cyc;
                last_wr = cyc;
                last_ev = cyc;
            end else begin
                stall_cnt++;
            end
        end
        if (read_o && rd_q.size() > 0) begin
            c = rd_q[0];
            chk("rd_addr", address_o, c.a);
            chk("rd_burstcount", burstcount_o, c.l);
            if (r_acc) begin
                void'(rd_q.pop_front());
                rd_log.push_back(address_o);
                acc_cyc.push_back(cyc);
                out_m++;
                for (int k = 0; k < int'(c.l); k++) begin
                    t = cyc + lat;
                    if (last_sched + 1 > t) t = last_sched + 1;
                    ret_q.push_back(t);
                    last_sched = t;
                end
            end
        end
        if (readdatavalid_i && test_on) begin
            rdv_cnt++; rbeats++; last_ev = cyc;
            if (rbeats % m_len == 0) begin
                out_m--;
                if (first_ret < 0) first_ret = cyc;
            end
        end
        if (out_m > max_out) max_out = out_m;
        if (phase == 1 && wr_q.size() == 0) phase = (rd_q.size() > 0) ? 2 : 0;
        if (busy_o) busy_cnt++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (test_on && done_at < 0 && wr_q.size() == 0 && rd_q.size() == 0 && out_m == 0 && ret_q.size() == 0)
            done_at = last_ev + 2;
        if (exp_done) begin
            test_on = 1'b0; done_at = -1; phase = 0;
        end
        if (start_test_i && !test_on) begin
            load_model(test_mode_i, start_addr_i, trans_count_i, burst_len_i);
            test_on = 1'b1; last_ev = cyc; done_at = -1;
        end
        prev_stall = (read_o || write_o) && waitrequest_i;
        prev_rd = read_o; prev_wr = write_o; prev_addr = address_o; prev_bc = burstcount_o;
    endtask

    // Compare process; also plays the in-order memory returning read beats.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc = cyc + 1;
            readdatavalid_i = 1'b0;
            if (ret_q.size() > 0 && ret_q[0] == cyc) begin
                readdatavalid_i = 1'b1;
                void'(ret_q.pop_front());
            end
            @(negedge clk_i);
            check_cycle();
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); acc_cyc.delete();
        rdv_cnt = 0; max_out = 0; first_ret = -1; first_wr = -1; last_wr = -1;
        done_cyc = -1; stall_cnt = 0; busy_cnt = 0; done_cnt = 0;
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [AW-1:0] addr,
                            input logic [31:0] cnt, input logic [BW-1:0] len);
        start_test_i = 1'b1; test_mode_i = mode; start_addr_i = addr;
        trans_count_i = cnt; burst_len_i = len;
        cyc_wait(1);
        start_test_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (test_on && n < budget) begin
            cyc_wait(1);
            n++;
        end
        chk("test_timeout", test_on, 1'b0);
        cyc_wait(2);
    endtask

    initial begin
        clear_logs();
        cyc_wait(3);
        rst_i = 1'b0;
        cyc_wait(2);

        // write-only, three bursts of four beats
        clear_logs();
        do_start(2'd0, 31'h100, 32'd3, 11'd4);
        wait_idle(200);
        chk("wo_beats", wr_log.size(), 12);
        chk("wo_addr0", wr_log[0], 31'h100);
        chk("wo_addr4", wr_log[4], 31'h104);
        chk("wo_addr11", wr_log[11], 31'h108);
        chk("wo_back_to_back", last_wr - first_wr, 11);
        chk("wo_done_delay", done_cyc - last_wr, 2);

        // read-only, six bursts of two beats, latency 20
        clear_logs();
        lat = 20;
        do_start(2'd1, 31'h2000, 32'd6, 11'd2);
        wait_idle(400);
        chk("ro_accepts", acc_cyc.size(), 6);
        chk("ro_max_outstanding", max_out, 4);
        chk("ro_rdv_beats", rdv_cnt, 12);
        chk("ro_first_four", acc_cyc[3] - acc_cyc[0], 3);
        chk("ro_fifth_accept", acc_cyc[4] - acc_cyc[0], 22);
        chk("ro_done_time", done_cyc - acc_cyc[0], 47);
        chk("ro_addr5", rd_log[5], 31'h200A);

        // write-then-read across the top of the address space
        clear_logs();
        lat = 3;
        do_start(2'd2, 31'h7FFFFFFE, 32'd2, 11'd1);
        wait_idle(200);
        chk("wr2_addr0", wr_log[0], 31'h7FFFFFFE);
        chk("wr2_addr1", wr_log[1], 31'h7FFFFFFF);
        chk("rd2_addr1", rd_log[1], 31'h7FFFFFFF);
        chk("wr2_done_time", done_cyc - first_wr, 8);

        clear_logs();
        do_start(2'd2, 31'h7FFFFFFE, 32'd3, 11'd1);
        wait_idle(200);
        chk("wrap_wr", wr_log[2], 31'h0);
        chk("wrap_rd0", rd_log[0], 31'h7FFFFFFE);
        chk("wrap_rd2", rd_log[2], 31'h0);

        // waitrequest stall of five cycles in the middle of a burst
        clear_logs();
        do_start(2'd0, 31'h40, 32'd2, 11'd4);
        cyc_wait(2);
        waitrequest_i = 1'b1;
        cyc_wait(5);
        waitrequest_i = 1'b0;
        wait_idle(200);
        chk("stall_beats", wr_log.size(), 8);
        chk("stall_cycles", stall_cnt, 5);
        chk("stall_addr7", wr_log[7], 31'h44);

        // zero bursts
        clear_logs();
        do_start(2'd0, 31'h80, 32'd0, 11'd4);
        wait_idle(50);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_no_cmds", wr_log.size() + rd_log.size(), 0);

        // reserved mode with zero burst length, then a start while busy
        clear_logs();
        do_start(2'd3, 31'h55, 32'd1, 11'd0);
        wait_idle(50);
        chk("mode3_beats", wr_log.size(), 1);
        chk("mode3_addr", wr_log[0], 31'h55);

        clear_logs();
        do_start(2'd0, 31'h200, 32'd2, 11'd2);
        cyc_wait(1);
        do_start(2'd1, 31'h300, 32'd5, 11'd3);
        wait_idle(100);
        chk("busy_start_beats", wr_log.size(), 4);
        chk("busy_start_addr3", wr_log[3], 31'h202);
        chk("busy_start_no_reads", rd_log.size(), 0);

        // reset in the middle of a read test
        clear_logs();
        lat = 20;
        do_start(2'd1, 31'h900, 32'd4, 11'd2);
        cyc_wait(6);
        rst_i = 1'b1;
        cyc_wait(2);
        rst_i = 1'b0;
        cyc_wait(1);
        chk("post_reset_outputs", {read_o, write_o, busy_o, done_o, address_o, burstcount_o}, 64'd0);
        cyc_wait(40);
        chk("reset_no_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
